// File: rtl/wu_inst_memory.sv
// WU instruction store: run-time loaded descriptor array with a write-first read path
// feeding a credit-controlled output buffer towards decode.
module wu_inst_memory #(
    parameter int DEPTH       = 1024,
    parameter int ADDR_W      = 10,
    parameter int CNTL_W      = 2,
    parameter int NUM_OPTS    = 3,
    parameter int OPT_TYPE_W  = 8,
    parameter int OPT_VALUE_W = 24,
    parameter int OBUF_DEPTH  = 4,
    localparam int WORD_W     = 2*CNTL_W + NUM_OPTS*(OPT_TYPE_W+OPT_VALUE_W)
) (
    input  logic                            clk,
    input  logic                            reset_poweron_n,
    input  logic                            ld__wum__valid,
    input  logic [ADDR_W-1:0]               ld__wum__addr,
    input  logic [WORD_W-1:0]               ld__wum__data,
    input  logic                            wuf__wum__read,
    input  logic [ADDR_W-1:0]               wuf__wum__addr,
    output logic                            wum__wuf__ready,
    input  logic                            wuf__wum__flush,
    output logic                            wum__wud__valid,
    input  logic                            wud__wum__ready,
    output logic [CNTL_W-1:0]               wum__wud__icntl,
    output logic [CNTL_W-1:0]               wum__wud__dcntl,
    output logic [NUM_OPTS*OPT_TYPE_W-1:0]  wum__wud__option_type,
    output logic [NUM_OPTS*OPT_VALUE_W-1:0] wum__wud__option_value,
    output logic                            wum__sys__addr_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PTR_W = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(OBUF_DEPTH + 1);
    localparam logic [ADDR_W:0]  DEPTH_LIM = (ADDR_W+1)'(DEPTH);
    localparam logic [CNT_W:0]   OBUF_LIM  = (CNT_W+1)'(OBUF_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(OBUF_DEPTH-1);

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return ({1'b0, addr} < DEPTH_LIM);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
    endfunction

    logic [WORD_W-1:0] mem_r  [DEPTH];
    logic [WORD_W-1:0] obuf_r [OBUF_DEPTH];
    logic              rd_pend_r;
    logic [ADDR_W-1:0] rd_addr_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              addr_err_r;

    logic              ready_s;
    logic              accept_s;
    logic              push_s;
    logic              pop_s;
    logic              valid_s;
    logic [CNT_W:0]    credit_s;
    logic [WORD_W-1:0] rd_word_s;
    logic [WORD_W-1:0] head_s;

    // Credit check: buffered entries plus the one read in flight must leave a free slot.
    always_comb begin
        credit_s = {1'b0, count_r} + (CNT_W+1)'(rd_pend_r);
        if (wuf__wum__flush) begin
            ready_s = 1'b0;
        end else begin
            ready_s = (credit_s < OBUF_LIM);
        end
    end

    assign accept_s = wuf__wum__read && ready_s;
    assign push_s   = rd_pend_r && !wuf__wum__flush;
    assign valid_s  = (count_r != '0);
    assign pop_s    = valid_s && wud__wum__ready;

    // Descriptor array write port; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (ld__wum__valid && in_range(ld__wum__addr)) begin
            mem_r[ld__wum__addr[IDX_W-1:0]] <= ld__wum__data;
        end
    end

    // Read request register: one accepted request per cycle.
    always_ff @(posedge clk or negedge reset_poweron_n) begin
        if (!reset_poweron_n) begin
            rd_pend_r <= 1'b0;
            rd_addr_r <= '0;
        end else if (wuf__wum__flush) begin
            rd_pend_r <= 1'b0;
        end else begin
            rd_pend_r <= accept_s;
            if (accept_s) begin
                rd_addr_r <= wuf__wum__addr;
            end
        end
    end

    // Array read with bypass of a same-cycle write; out-of-range reads yield zero.
    always_comb begin
        rd_word_s = '0;
        if (!in_range(rd_addr_r)) begin
            rd_word_s = '0;
        end else if (ld__wum__valid && (ld__wum__addr == rd_addr_r)) begin
            rd_word_s = ld__wum__data;
        end else begin
            rd_word_s = mem_r[rd_addr_r[IDX_W-1:0]];
        end
    end

    // Output buffer storage, written at the tail on every push.
    always_ff @(posedge clk) begin
        if (push_s) begin
            obuf_r[wr_ptr_r] <= rd_word_s;
        end
    end

    // Output buffer pointers and occupancy.
    always_ff @(posedge clk or negedge reset_poweron_n) begin
        if (!reset_poweron_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (wuf__wum__flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= ptr_next(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_next(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky address error, cleared only by power-on reset.
    always_ff @(posedge clk or negedge reset_poweron_n) begin
        if (!reset_poweron_n) begin
            addr_err_r <= 1'b0;
        end else if ((ld__wum__valid && !in_range(ld__wum__addr)) ||
                     (accept_s && !in_range(wuf__wum__addr))) begin
            addr_err_r <= 1'b1;
        end else begin
            addr_err_r <= addr_err_r;
        end
    end

    // Head of buffer towards decode, zero whenever nothing is valid.
    always_comb begin
        head_s = '0;
        if (valid_s) begin
            head_s = obuf_r[rd_ptr_r];
        end else begin
            head_s = '0;
        end
    end

    assign wum__wuf__ready        = ready_s;
    assign wum__wud__valid        = valid_s;
    assign wum__wud__icntl        = head_s[WORD_W-1 -: CNTL_W];
    assign wum__wud__dcntl        = head_s[WORD_W-CNTL_W-1 -: CNTL_W];
    assign wum__wud__option_type  = head_s[NUM_OPTS*(OPT_TYPE_W+OPT_VALUE_W)-1 -: NUM_OPTS*OPT_TYPE_W];
    assign wum__wud__option_value = head_s[NUM_OPTS*OPT_VALUE_W-1:0];
    assign wum__sys__addr_err     = addr_err_r;

endmodule

// File: tb/tb_wu_inst_memory.sv
// Self-checking bench for wu_inst_memory: directed scenarios plus random traffic against a
// queue-based reference model of the store, the credit rule and the output FIFO.
module tb_wu_inst_memory;

    localparam int DEPTH       = 1024;
    localparam int ADDR_W      = 11;
    localparam int CNTL_W      = 2;
    localparam int NUM_OPTS    = 3;
    localparam int OPT_TYPE_W  = 8;
    localparam int OPT_VALUE_W = 24;
    localparam int OBUF_DEPTH  = 4;
    localparam int WORD_W      = 2*CNTL_W + NUM_OPTS*(OPT_TYPE_W+OPT_VALUE_W);

    logic                            clk = 1'b0;
    logic                            reset_poweron_n;
    logic                            ld__wum__valid;
    logic [ADDR_W-1:0]               ld__wum__addr;
    logic [WORD_W-1:0]               ld__wum__data;
    logic                            wuf__wum__read;
    logic [ADDR_W-1:0]               wuf__wum__addr;
    logic                            wum__wuf__ready;
    logic                            wuf__wum__flush;
    logic                            wum__wud__valid;
    logic                            wud__wum__ready;
    logic [CNTL_W-1:0]               wum__wud__icntl;
    logic [CNTL_W-1:0]               wum__wud__dcntl;
    logic [NUM_OPTS*OPT_TYPE_W-1:0]  wum__wud__option_type;
    logic [NUM_OPTS*OPT_VALUE_W-1:0] wum__wud__option_value;
    logic                            wum__sys__addr_err;

    always #5 clk = ~clk;

    wu_inst_memory #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNTL_W(CNTL_W), .NUM_OPTS(NUM_OPTS),
        .OPT_TYPE_W(OPT_TYPE_W), .OPT_VALUE_W(OPT_VALUE_W), .OBUF_DEPTH(OBUF_DEPTH)
    ) dut (
        .clk(clk),
        .reset_poweron_n(reset_poweron_n),
        .ld__wum__valid(ld__wum__valid),
        .ld__wum__addr(ld__wum__addr),
        .ld__wum__data(ld__wum__data),
        .wuf__wum__read(wuf__wum__read),
        .wuf__wum__addr(wuf__wum__addr),
        .wum__wuf__ready(wum__wuf__ready),
        .wuf__wum__flush(wuf__wum__flush),
        .wum__wud__valid(wum__wud__valid),
        .wud__wum__ready(wud__wum__ready),
        .wum__wud__icntl(wum__wud__icntl),
        .wum__wud__dcntl(wum__wud__dcntl),
        .wum__wud__option_type(wum__wud__option_type),
        .wum__wud__option_value(wum__wud__option_value),
        .wum__sys__addr_err(wum__sys__addr_err)
    );

    // Reference model state
    logic [WORD_W-1:0] mem_m [DEPTH];
    logic [WORD_W-1:0] q_m [$];
    logic              pend_v;
    logic [ADDR_W-1:0] pend_a;
    logic              err_m;
    logic              ready_m;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WORD_W-1:0] rand_word();
        logic [127:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom()};
        return t[WORD_W-1:0];
    endfunction

    task automatic model_reset();
        q_m.delete();
        pend_v = 1'b0;
        pend_a = '0;
        err_m  = 1'b0;
    endtask

    task automatic check_outputs();
        logic [WORD_W-1:0] e;
        e = (q_m.size() > 0) ? q_m[0] : '0;
        ready_m = !wuf__wum__flush && ((q_m.size() + (pend_v ? 1 : 0)) < OBUF_DEPTH);
        chk("valid",  128'(wum__wud__valid), 128'(q_m.size() > 0));
        chk("ready",  128'(wum__wuf__ready), 128'(ready_m));
        chk("icntl",  128'(wum__wud__icntl), 128'(e[99:98]));
        chk("dcntl",  128'(wum__wud__dcntl), 128'(e[97:96]));
        chk("otype",  128'(wum__wud__option_type), 128'(e[95:72]));
        chk("ovalue", 128'(wum__wud__option_value), 128'(e[71:0]));
        chk("addr_err", 128'(wum__sys__addr_err), 128'(err_m));
    endtask

    task automatic model_update();
        if (!reset_poweron_n) begin
            model_reset();
        end else begin
            if (ld__wum__valid) begin
                if (int'(ld__wum__addr) < DEPTH) mem_m[ld__wum__addr[9:0]] = ld__wum__data;
                else err_m = 1'b1;
            end
            if (wuf__wum__flush) begin
                q_m.delete();
                pend_v = 1'b0;
            end else begin
                if ((q_m.size() > 0) && wud__wum__ready) void'(q_m.pop_front());
                if (pend_v) q_m.push_back((int'(pend_a) < DEPTH) ? mem_m[pend_a[9:0]] : '0);
                pend_v = wuf__wum__read && ready_m;
                if (pend_v) begin
                    pend_a = wuf__wum__addr;
                    if (int'(wuf__wum__addr) >= DEPTH) err_m = 1'b1;
                end
            end
        end
    endtask

    // One clock cycle: check mid-cycle, update the model at the edge, release inputs after.
    task automatic tick();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        ld__wum__valid  = 1'b0;
        wuf__wum__read  = 1'b0;
        wuf__wum__flush = 1'b0;
    endtask

    task automatic load(input int addr, input logic [WORD_W-1:0] data);
        idle();
        ld__wum__valid = 1'b1;
        ld__wum__addr  = ADDR_W'(addr);
        ld__wum__data  = data;
        tick();
        ld__wum__valid = 1'b0;
    endtask

    task automatic read(input int addr);
        idle();
        wuf__wum__read = 1'b1;
        wuf__wum__addr = ADDR_W'(addr);
        tick();
        wuf__wum__read = 1'b0;
    endtask

    initial begin
        reset_poweron_n = 1'b0;
        idle();
        ld__wum__addr   = '0;
        ld__wum__data   = '0;
        wuf__wum__addr  = '0;
        wud__wum__ready = 1'b1;
        model_reset();
        ready_m = 1'b1;
        tick();
        tick();
        @(negedge clk);
        reset_poweron_n = 1'b1;
        @(posedge clk);
        #1;

        // Load a working set; addresses 0..3 get distinct words.
        for (int a = 0; a < 64; a++) load(a, rand_word());

        // Back-to-back reads, decode always ready.
        for (int a = 0; a < 4; a++) read(a);
        for (int i = 0; i < 4; i++) tick();

        // Backpressure: stream reads while decode stalls, then release.
        wud__wum__ready = 1'b0;
        for (int i = 0; i < 8; i++) read(10 + i);
        chk("bp_full", 128'(q_m.size()), 128'(OBUF_DEPTH));
        wud__wum__ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();

        // Write-first: read addr 5, write addr 5 the following cycle.
        read(5);
        load(5, {4'hA, rand_word()} >> 4 | {4'hA, 96'h0});
        for (int i = 0; i < 3; i++) tick();

        // Out-of-range read returns zeros and sets the sticky error.
        read(DEPTH);
        for (int i = 0; i < 3; i++) tick();
        read(2047);
        for (int i = 0; i < 3; i++) tick();

        // Fill buffer to 3, flush with a concurrent read, then a fresh read.
        wud__wum__ready = 1'b0;
        for (int a = 0; a < 3; a++) read(a);
        tick();
        tick();
        chk("fill3", 128'(q_m.size()), 128'(3));
        wud__wum__ready = 1'b1;
        wuf__wum__read  = 1'b1;
        wuf__wum__addr  = ADDR_W'(2);
        wuf__wum__flush = 1'b1;
        tick();
        idle();
        read(1);
        for (int i = 0; i < 3; i++) tick();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            ld__wum__valid  = ($urandom_range(0, 9) < 3);
            ld__wum__addr   = ADDR_W'($urandom_range(0, 63));
            ld__wum__data   = rand_word();
            wuf__wum__read  = ($urandom_range(0, 9) < 7);
            wuf__wum__addr  = ($urandom_range(0, 19) == 0) ? ADDR_W'($urandom_range(DEPTH, 2047))
                                                          : ADDR_W'($urandom_range(0, 63));
            wuf__wum__flush = ($urandom_range(0, 19) == 0);
            wud__wum__ready = ($urandom_range(0, 9) < 6);
            tick();
        end
        idle();

        // Asynchronous reset while an instruction is being presented.
        wud__wum__ready = 1'b0;
        read(7);
        read(8);
        tick();
        chk("pre_rst_valid", 128'(wum__wud__valid), 128'(1));
        #2;
        reset_poweron_n = 1'b0;
        #1;
        model_reset();
        chk("rst_valid",  128'(wum__wud__valid), 128'(0));
        chk("rst_ready",  128'(wum__wuf__ready), 128'(1));
        chk("rst_icntl",  128'(wum__wud__icntl), 128'(0));
        chk("rst_ovalue", 128'(wum__wud__option_value), 128'(0));
        chk("rst_err",    128'(wum__sys__addr_err), 128'(0));
        tick();
        @(negedge clk);
        reset_poweron_n = 1'b1;
        @(posedge clk);
        #1;
        wud__wum__ready = 1'b1;
        for (int a = 0; a < 4; a++) load(a, rand_word());
        for (int a = 0; a < 4; a++) read(a);
        for (int i = 0; i < 5; i++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
